equiv_mismatch_monitor: RTL and testbench

Downstream consumer of the two-instance equivalence harness. It takes the paired outputs `y_1`/`y_2` each valid cycle, ignores a warm-up window after reset, and then compares the pair. It counts compares and mismatches, and captures the first mismatch: sample index, XOR difference vector and differing-bit count. Status is reported through a small state machine, so simulation benches can report a failure location instead of only a bare assertion failure.

---
 rtl/equiv_mismatch_monitor.sv | 143 ++++++++++++++
 tb/tb_equiv_mismatch_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/equiv_mismatch_monitor.sv
// Compares the paired outputs of two design instances after a warm-up window,
// counting compares/mismatches and capturing the location and shape of the first mismatch.
module equiv_mismatch_monitor #(
  parameter int WIDTH        = 91,
  parameter int WARMUP       = 4,
  parameter int MAX_COMPARES = 1024,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 1,
  parameter int NB_W         = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] y_1_i,
  input  logic [WIDTH-1:0] y_2_i,
  output logic [1:0]       state_o,
  output logic             fail_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sample_idx_o,
  output logic [CNT_W-1:0] cmp_count_o,
  output logic [CNT_W-1:0] mis_count_o,
  output logic [CNT_W-1:0] first_idx_o,
  output logic [WIDTH-1:0] first_diff_o,
  output logic [NB_W-1:0]  first_nbits_o
);

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_COMPARE = 2'd1,
    ST_FAIL    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] WARMUP_C  = CNT_W'(WARMUP);
  localparam logic [CNT_W-1:0] MAX_CMP_C = CNT_W'(MAX_COMPARES);
  // With no warm-up window the very first sample after reset is already compared.
  localparam state_e RESET_STATE = (WARMUP == 0) ? ST_COMPARE : ST_WARMUP;

  state_e           state_q, state_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] sample_idx_q, sample_idx_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic [WIDTH-1:0] first_diff_q, first_diff_d;
  logic [NB_W-1:0]  first_nbits_q, first_nbits_d;

  logic [WIDTH-1:0] diff;
  logic             mismatch;
  logic [NB_W-1:0]  diff_nbits;
  logic [CNT_W-1:0] sample_inc, cmp_inc, mis_inc;

  always_comb begin
    diff       = y_1_i ^ y_2_i;
    mismatch   = |diff;
    diff_nbits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff_nbits = diff_nbits + NB_W'(diff[i]);
    end
    sample_inc = (sample_idx_q == CNT_MAX) ? sample_idx_q : sample_idx_q + 1'b1;
    cmp_inc    = (cmp_q == CNT_MAX) ? cmp_q : cmp_q + 1'b1;
    mis_inc    = (mis_q == CNT_MAX) ? mis_q : mis_q + 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    fail_d        = fail_q;
    sample_idx_d  = sample_idx_q;
    cmp_d         = cmp_q;
    mis_d         = mis_q;
    first_idx_d   = first_idx_q;
    first_diff_d  = first_diff_q;
    first_nbits_d = first_nbits_q;
    if (in_valid_i) begin
      unique case (state_q)
        ST_WARMUP: begin
          sample_idx_d = sample_inc;
          if (sample_inc == WARMUP_C) begin
            state_d = ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          sample_idx_d = sample_inc;
          cmp_d        = cmp_inc;
          if (mismatch) begin
            mis_d = mis_inc;
            if (!fail_q) begin
              fail_d        = 1'b1;
              first_idx_d   = sample_idx_q;
              first_diff_d  = diff;
              first_nbits_d = diff_nbits;
            end
          end
          // A stopping mismatch wins over reaching the compare budget on the same sample.
          if (mismatch && (STOP_ON_FAIL != 0)) begin
            state_d = ST_FAIL;
          end else if (cmp_inc == MAX_CMP_C) begin
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RESET_STATE;
      fail_q        <= 1'b0;
      done_q        <= 1'b0;
      sample_idx_q  <= '0;
      cmp_q         <= '0;
      mis_q         <= '0;
      first_idx_q   <= '0;
      first_diff_q  <= '0;
      first_nbits_q <= '0;
    end else begin
      state_q       <= state_d;
      fail_q        <= fail_d;
      done_q        <= done_d;
      sample_idx_q  <= sample_idx_d;
      cmp_q         <= cmp_d;
      mis_q         <= mis_d;
      first_idx_q   <= first_idx_d;
      first_diff_q  <= first_diff_d;
      first_nbits_q <= first_nbits_d;
    end
  end

  assign state_o       = state_q;
  assign fail_o        = fail_q;
  assign done_o        = done_q;
  assign sample_idx_o  = sample_idx_q;
  assign cmp_count_o   = cmp_q;
  assign mis_count_o   = mis_q;
  assign first_idx_o   = first_idx_q;
  assign first_diff_o  = first_diff_q;
  assign first_nbits_o = first_nbits_q;

endmodule

// File: tb/tb_equiv_mismatch_monitor.sv
// Drives five differently-parameterised monitors with directed and random sample streams
// and checks every output against a sample-level reference model each cycle.
module tb_equiv_mismatch_monitor;

  localparam int N = 5;
  localparam int W = 91;
  localparam int CW = 16;
  localparam int CNT_SAT = 65535;
  localparam int WARM[N]  = '{4, 4, 4, 4, 0};
  localparam int MAXC[N]  = '{1024, 1024, 8, 8, 5};
  localparam int STOP[N]  = '{1, 0, 1, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstIn[N];
  logic         vldIn[N];
  logic [W-1:0] y1In[N];
  logic [W-1:0] y2In[N];

  logic [1:0]    stateO[N];
  logic          failO[N];
  logic          doneO[N];
  logic [CW-1:0] sidxO[N];
  logic [CW-1:0] cmpO[N];
  logic [CW-1:0] misO[N];
  logic [CW-1:0] fidxO[N];
  logic [W-1:0]  fdiffO[N];
  logic [6:0]    fnbO[N];

  for (genvar g = 0; g < N; g++) begin : gDut
    equiv_mismatch_monitor #(
      .WIDTH(W), .WARMUP(WARM[g]), .MAX_COMPARES(MAXC[g]),
      .CNT_W(CW), .STOP_ON_FAIL(STOP[g]), .NB_W(7)
    ) dut (
      .clk_i(clk), .rst_i(rstIn[g]), .in_valid_i(vldIn[g]),
      .y_1_i(y1In[g]), .y_2_i(y2In[g]),
      .state_o(stateO[g]), .fail_o(failO[g]), .done_o(doneO[g]),
      .sample_idx_o(sidxO[g]), .cmp_count_o(cmpO[g]), .mis_count_o(misO[g]),
      .first_idx_o(fidxO[g]), .first_diff_o(fdiffO[g]), .first_nbits_o(fnbO[g])
    );
  end

  // Reference model: phase 0=warm-up, 1=comparing, 2=stopped on failure, 3=budget used up.
  int           mState[N];
  int           mFail[N];
  int           mSidx[N];
  int           mCmp[N];
  int           mMis[N];
  int           mFirstIdx[N];
  logic [W-1:0] mFirstDiff[N];
  int           mNbits[N];

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand91();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  function automatic int sat(input int x);
    return (x >= CNT_SAT) ? CNT_SAT : x + 1;
  endfunction

  task automatic modelStep(input int k);
    int idx;
    logic [W-1:0] d;
    if (rstIn[k]) begin
      mState[k] = (WARM[k] == 0) ? 1 : 0;
      mFail[k] = 0; mSidx[k] = 0; mCmp[k] = 0; mMis[k] = 0;
      mFirstIdx[k] = 0; mFirstDiff[k] = '0; mNbits[k] = 0;
    end else if (vldIn[k] && mState[k] < 2) begin
      idx = mSidx[k];
      mSidx[k] = sat(idx);
      if (mState[k] == 0) begin
        if (mSidx[k] == WARM[k]) mState[k] = 1;
      end else begin
        mCmp[k] = sat(mCmp[k]);
        d = y1In[k] ^ y2In[k];
        if (d != '0) begin
          mMis[k] = sat(mMis[k]);
          if (mFail[k] == 0) begin
            mFail[k] = 1;
            mFirstIdx[k] = idx;
            mFirstDiff[k] = d;
            mNbits[k] = $countones(d);
          end
        end
        if (d != '0 && STOP[k] != 0) mState[k] = 2;
        else if (mCmp[k] == MAXC[k]) mState[k] = 3;
      end
    end
  endtask

  task automatic compareAll();
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("dut%0d.state", k), 128'(stateO[k]), 128'(mState[k]));
      checkOutput($sformatf("dut%0d.fail", k), 128'(failO[k]), 128'(mFail[k]));
      checkOutput($sformatf("dut%0d.done", k), 128'(doneO[k]), 128'(mState[k] == 3));
      checkOutput($sformatf("dut%0d.sample_idx", k), 128'(sidxO[k]), 128'(mSidx[k]));
      checkOutput($sformatf("dut%0d.cmp_count", k), 128'(cmpO[k]), 128'(mCmp[k]));
      checkOutput($sformatf("dut%0d.mis_count", k), 128'(misO[k]), 128'(mMis[k]));
      checkOutput($sformatf("dut%0d.first_idx", k), 128'(fidxO[k]), 128'(mFirstIdx[k]));
      checkOutput($sformatf("dut%0d.first_diff", k), 128'(fdiffO[k]), 128'(mFirstDiff[k]));
      checkOutput($sformatf("dut%0d.first_nbits", k), 128'(fnbO[k]), 128'(mNbits[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < N; k++) modelStep(k);
    @(negedge clk);
    compareAll();
  endtask

  // directed=1 follows the scripted scenario per monitor, keyed on the upcoming sample index.
  task automatic applyStimulus(input bit directed);
    logic [W-1:0] base, flip;
    int s;
    for (int k = 0; k < N; k++) begin
      rstIn[k] = 1'b0;
      vldIn[k] = ($urandom_range(0, 3) != 0);
      base = rand91();
      s = mSidx[k];
      flip = '0;
      if (!directed || k == 4) begin
        if ($urandom_range(0, 5) == 0) flip = rand91() | W'(1);
      end else begin
        case (k)
          0: if (s >= 10) begin flip[0] = 1'b1; flip[90] = 1'b1; end
          1: begin
            if (s == 6) flip[3] = 1'b1;
            if (s == 9) begin flip[50] = 1'b1; flip[7] = 1'b1; end
            if (s == 12) begin flip[1] = 1'b1; flip[2] = 1'b1; flip[80] = 1'b1; end
          end
          3: if (s == 11) flip[5] = 1'b1;
          default: ;
        endcase
      end
      if (directed && k == 0 && s < 4) begin
        y1In[k] = '0;
        y2In[k] = '1;
      end else begin
        y1In[k] = base ^ flip;
        y2In[k] = base;
      end
    end
  endtask

  task automatic resetAll();
    for (int k = 0; k < N; k++) begin
      rstIn[k] = 1'b1;
      vldIn[k] = 1'b1;
      y1In[k] = rand91();
      y2In[k] = rand91();
    end
  endtask

  initial begin
    logic [W-1:0] expA;
    bit warmChecked;
    bit reached;
    int cycles;

    // Reset held for two cycles, with in_valid high to show rst wins.
    resetAll();
    @(negedge clk);
    tick();
    tick();
    checkOutput("reset.state", 128'(stateO[0]), 128'(0));
    checkOutput("reset.sample_idx", 128'(sidxO[0]), 128'(0));
    checkOutput("reset.first_diff", 128'(fdiffO[0]), 128'(0));
    checkOutput("reset.state_w0", 128'(stateO[4]), 128'(1));

    warmChecked = 1'b0;
    reached = 1'b0;
    cycles = 0;
    while (!reached && cycles < 300) begin
      applyStimulus(1'b1);
      tick();
      cycles++;
      if (!warmChecked && mSidx[0] == 5) begin
        warmChecked = 1'b1;
        checkOutput("warm.state", 128'(stateO[0]), 128'(1));
        checkOutput("warm.sample_idx", 128'(sidxO[0]), 128'(5));
        checkOutput("warm.cmp_count", 128'(cmpO[0]), 128'(1));
        checkOutput("warm.fail", 128'(failO[0]), 128'(0));
      end
      reached = (mState[0] == 2) && (mSidx[1] >= 14) && (mState[2] == 3) && (mState[3] >= 2);
    end
    checkOutput("scenario.reached", 128'(reached), 128'(1));

    // Captured mismatch remains fixed while more samples arrive.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1);
      vldIn[0] = 1'b1;
      tick();
    end
    expA = '0;
    expA[0] = 1'b1;
    expA[90] = 1'b1;
    checkOutput("stop.state", 128'(stateO[0]), 128'(2));
    checkOutput("stop.fail", 128'(failO[0]), 128'(1));
    checkOutput("stop.first_idx", 128'(fidxO[0]), 128'(10));
    checkOutput("stop.first_diff", 128'(fdiffO[0]), 128'(expA));
    checkOutput("stop.first_nbits", 128'(fnbO[0]), 128'(2));
    checkOutput("stop.mis_count", 128'(misO[0]), 128'(1));
    checkOutput("stop.sample_idx", 128'(sidxO[0]), 128'(11));

    checkOutput("cont.mis_count", 128'(misO[1]), 128'(3));
    checkOutput("cont.first_idx", 128'(fidxO[1]), 128'(6));
    checkOutput("cont.first_diff", 128'(fdiffO[1]), 128'(W'(8)));
    checkOutput("cont.first_nbits", 128'(fnbO[1]), 128'(1));
    checkOutput("cont.state", 128'(stateO[1]), 128'(1));

    checkOutput("done.done", 128'(doneO[2]), 128'(1));
    checkOutput("done.state", 128'(stateO[2]), 128'(3));
    checkOutput("done.sample_idx", 128'(sidxO[2]), 128'(12));
    checkOutput("done.cmp_count", 128'(cmpO[2]), 128'(8));

    checkOutput("prio.state", 128'(stateO[3]), 128'(2));
    checkOutput("prio.done", 128'(doneO[3]), 128'(0));
    checkOutput("prio.first_idx", 128'(fidxO[3]), 128'(11));
    checkOutput("prio.cmp_count", 128'(cmpO[3]), 128'(8));

    // Mid-run reset while comparing with a recorded failure.
    resetAll();
    tick();
    checkOutput("midrst.state", 128'(stateO[1]), 128'(0));
    checkOutput("midrst.fail", 128'(failO[1]), 128'(0));
    checkOutput("midrst.mis_count", 128'(misO[1]), 128'(0));
    checkOutput("midrst.first_idx", 128'(fidxO[1]), 128'(0));
    checkOutput("midrst.first_diff", 128'(fdiffO[1]), 128'(0));

    // Random soak with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 59) == 0) rstIn[k] = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
